// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one multi-cycle signed fixed-point
// divider among NREQ requesters. One division in flight at a time, with
// valid/ready handshakes on both the request and response sides.
// Optional feature macro: DIV_ZERO_CHECK_EN
//   When it is defined, a d==0 request bypasses the divider, returns a
//   saturated quotient, and raises dz_flag.
// The file also contains the shared divider `div`: a restoring divider on
// magnitudes. Its done output rises WIDTH-1+FBITS cycles after start.

module div #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  localparam int DW = WIDTH + FBITS;
  localparam int CW = $clog2(DW + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rem_q, rem_d, dm_q, dm_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] n_mag, d_mag, src_rem, src_dm;
  logic [DW-1:0]    src_dvd;
  logic [WIDTH:0]   trial, diff;
  logic             ge;

  // One restoring step per cycle; the load cycle already performs the first step.
  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path leaves a latch.
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dm_d      = dm_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    n_mag     = n[WIDTH-1] ? -n : n;
    d_mag     = d[WIDTH-1] ? -d : d;
    if (start) begin
      src_rem = '0;
      src_dvd = {n_mag, {FBITS{1'b0}}};
      src_dm  = d_mag;
    end else begin
      src_rem = rem_q;
      src_dvd = dvd_q;
      src_dm  = dm_q;
    end
    trial = {src_rem, src_dvd[DW-1]};
    ge    = trial >= {1'b0, src_dm};
    diff  = trial - {1'b0, src_dm};
    if (start) begin
      rem_d     = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      dvd_d     = {src_dvd[DW-2:0], ge};
      dm_d      = src_dm;
      neg_quo_d = n[WIDTH-1] ^ d[WIDTH-1];
      neg_rem_d = n[WIDTH-1];
      cnt_d     = CW'(DW - 1);
    end else if (cnt_q != '0) begin
      rem_d  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      dvd_d  = {src_dvd[DW-2:0], ge};
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  // Control state: the iteration counter and the done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Datapath registers: only read while a division is counting or done.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are deliberately not reset; control gates their use.
    rem_q     <= rem_d;
    dvd_q     <= dvd_d;
    dm_q      <= dm_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
  end

  assign done = done_q;
  assign q    = neg_quo_q ? -dvd_q[WIDTH-1:0] : dvd_q[WIDTH-1:0];
  assign r    = neg_rem_q ? -rem_q : rem_q;
endmodule

module div_arbiter #(
  parameter int  WIDTH = 32,
  parameter int  FBITS = 16,
  parameter int  NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_n,
  input  logic [NREQ*WIDTH-1:0] req_d,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_q,
  output logic [WIDTH-1:0]      resp_r,
  output logic                  busy
`ifdef DIV_ZERO_CHECK_EN
  , output logic                dz_flag
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d, id_q, id_d, resp_id_q, resp_id_d;
  logic [WIDTH-1:0] op_n_q, op_n_d, op_d_q, op_d_d;
  logic [WIDTH-1:0] resp_q_q, resp_q_d, resp_r_q, resp_r_d;
  logic             resp_valid_q, resp_valid_d;
  logic             dz_q, dz_d;
  logic             grant_vld;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] grant_n, grant_d;
  logic             div_done;
  logic [WIDTH-1:0] div_q, div_r;

  // Round-robin pick: the first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld && req_valid[(int'(rr_ptr_q) + i) % NREQ]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'((int'(rr_ptr_q) + i) % NREQ);
      end
    end
    grant_n = req_n[grant_id*WIDTH +: WIDTH];
    grant_d = req_d[grant_id*WIDTH +: WIDTH];
  end

  // Accept is offered only in IDLE and only to the winner; it is held low during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && grant_vld) req_ready[grant_id] = 1'b1;
  end

  div #(.WIDTH(WIDTH), .FBITS(FBITS)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .start(state_q == S_ISSUE),
    .n    (op_n_q),
    .d    (op_d_q),
    .done (div_done),
    .q    (div_q),
    .r    (div_r)
  );

  // FSM next-state: grant in IDLE, pulse start in ISSUE, collect in WAIT, hold in RESP.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    op_n_d       = op_n_q;
    op_d_d       = op_d_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_q_d     = resp_q_q;
    resp_r_d     = resp_r_q;
    dz_d         = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          op_n_d = grant_n;
          op_d_d = grant_d;
          id_d   = grant_id;
`ifdef DIV_ZERO_CHECK_EN
          if (grant_d == '0) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_id_d    = grant_id;
            resp_q_d     = grant_n[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            resp_r_d     = '0;
            dz_d         = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (div_done) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_id_d    = id_q;
          resp_q_d     = div_q;
          resp_r_d     = div_r;
          dz_d         = 1'b0;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          rr_ptr_d     = (resp_id_q == IDW'(NREQ - 1)) ? '0 : resp_id_q + IDW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All arbiter state and the registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      op_n_q       <= '0;
      op_d_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_q_q     <= '0;
      resp_r_q     <= '0;
      dz_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      op_n_q       <= op_n_d;
      op_d_q       <= op_d_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_q_q     <= resp_q_d;
      resp_r_q     <= resp_r_d;
      dz_q         <= dz_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_q     = resp_q_q;
  assign resp_r     = resp_r_q;
  assign busy       = (state_q != S_IDLE);
`ifdef DIV_ZERO_CHECK_EN
  assign dz_flag    = dz_q;
`else
  logic unused_dz;
  assign unused_dz  = dz_q;
`endif
endmodule

// File: tb/tb_div_arbiter.sv
// Testbench for div_arbiter: a reference model of the round-robin grant, the
// FSM idle/busy state, and the fixed-point division. Expected responses are
// queued at grant time and compared while the DUT presents them.
module tb_div_arbiter;
  localparam int WIDTH = 32;
  localparam int FBITS = 16;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int MAXJ  = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_n = '0;
  logic [NREQ*WIDTH-1:0] req_d = '0;
  logic                  resp_valid;
  logic                  resp_ready = 1'b1;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_q, resp_r;
  logic                  busy;
`ifdef DIV_ZERO_CHECK_EN
  logic                  dz_flag;
`endif

  div_arbiter #(.WIDTH(WIDTH), .FBITS(FBITS), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n     (req_n),
    .req_d     (req_d),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_q    (resp_q),
    .resp_r    (resp_r),
    .busy      (busy)
`ifdef DIV_ZERO_CHECK_EN
    , .dz_flag (dz_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   mptr = 0;
  bit   model_idle = 1'b1;
  bit   prev_rv = 1'b0;
  bit   prev_acc = 1'b0;
  logic [NREQ-1:0]  hs_mask = '0;
  logic [WIDTH-1:0] job_n [NREQ][MAXJ];
  logic [WIDTH-1:0] job_d [NREQ][MAXJ];
  int   job_cnt [NREQ];
  int   job_idx [NREQ];
  int   rdy_count [NREQ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic exp_t model(input int id, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    exp_t   e;
    longint nn, dd;
    e.id  = IDW'(id);
    e.dz  = 1'b0;
    e.lat = 50;
    nn = longint'($signed(n)) <<< FBITS;
    dd = longint'($signed(d));
    if (dd != 0) begin
      e.q = WIDTH'(nn / dd);
      e.r = WIDTH'(nn % dd);
    end else begin
      e.q = '0;
      e.r = '0;
    end
`ifdef DIV_ZERO_CHECK_EN
    if (dd == 0) begin
      e.q   = n[WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.r   = '0;
      e.dz  = 1'b1;
      e.lat = 1;
    end
`endif
    return e;
  endfunction

  function automatic int pending();
    int p = sb.size() + (model_idle ? 0 : 1);
    for (int i = 0; i < NREQ; i++) p += job_cnt[i] - job_idx[i];
    return p;
  endfunction

  // Called at each negedge: model the grant, compare, and update the scoreboard.
  task automatic sample();
    int              g;
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    if (!rst_n) begin
      model_idle = 1'b1;
      mptr       = 0;
      sb.delete();
      prev_rv    = 1'b0;
      prev_acc   = 1'b0;
      hs_mask    = '0;
      return;
    end
    g       = model_idle ? rr_pick(req_valid, mptr) : -1;
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    check("req_ready", req_ready, exp_rdy);
    check("busy", busy, !model_idle);
    for (int i = 0; i < NREQ; i++) rdy_count[i] += int'(req_ready[i]);
    if (prev_rv && !prev_acc) check("resp_valid_held", resp_valid, 1'b1);
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("resp_valid_spurious", resp_valid, 1'b0);
      end else begin
        e = sb[0];
        if (!prev_rv) check("latency", cyc - hs_cyc, e.lat);
        check("resp_id", resp_id, e.id);
        check("resp_q", resp_q, e.q);
        check("resp_r", resp_r, e.r);
`ifdef DIV_ZERO_CHECK_EN
        check("dz_flag", dz_flag, e.dz);
`endif
        if (resp_ready) begin
          void'(sb.pop_front());
          mptr       = (int'(e.id) + 1) % NREQ;
          model_idle = 1'b1;
        end
      end
    end
    if (g >= 0) begin
      sb.push_back(model(g, job_n[g][job_idx[g]], job_d[g][job_idx[g]]));
      model_idle = 1'b0;
      hs_cyc     = cyc;
    end
    hs_mask  = exp_rdy;
    prev_rv  = resp_valid;
    prev_acc = resp_valid && resp_ready;
  endtask

  task automatic load(input int i);
    req_n[i*WIDTH +: WIDTH] = job_n[i][job_idx[i]];
    req_d[i*WIDTH +: WIDTH] = job_d[i][job_idx[i]];
    req_valid[i]            = 1'b1;
  endtask

  task automatic add_job(input int i, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    if (job_cnt[i] < MAXJ) begin
      job_n[i][job_cnt[i]] = n;
      job_d[i][job_cnt[i]] = d;
      job_cnt[i]++;
      if (!req_valid[i]) load(i);
    end
  endtask

  // One clock: sample at the negedge, then update drivers just after the posedge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs_mask[i]) begin
        job_idx[i]++;
        if (job_idx[i] < job_cnt[i]) load(i);
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      job_cnt[i]   = 0;
      job_idx[i]   = 0;
      rdy_count[i] = 0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (pending() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain_done", pending(), 0);
  endtask

  initial begin
    int k;
    resp_ready = 1'b1;

    // Reset with every requester asserting valid.
    rst_n     = 1'b0;
    req_valid = '1;
    req_n     = {NREQ{32'h0001_0000}};
    req_d     = {NREQ{32'h0001_0000}};
    repeat (3) tick();
    check("rst_req_ready", req_ready, '0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_q", resp_q, '0);
    check("rst_resp_id", resp_id, '0);
    do_reset();

    // A single unsigned division on requester 0.
    add_job(0, 32'h0003_0000, 32'h0002_0000);
    drain(200);

    // A signed division on requester 2.
    add_job(2, 32'hFFFA_0000, 32'h0004_0000);
    drain(200);

    // Reset in the middle of a division: it is abandoned and nothing is returned.
    add_job(1, 32'h0007_0000, 32'h0003_0000);
    repeat (20) tick();
    do_reset();
    check("abort_busy", busy, 1'b0);
    repeat (60) tick();
    check("abort_resp_valid", resp_valid, 1'b0);

    // Round-robin: all four requesters are valid, and requester 0 has a second job.
    add_job(0, 32'h000A_0000, 32'h0003_0000);
    add_job(1, 32'hFFF0_0000, 32'h0005_0000);
    add_job(2, 32'h0001_8000, 32'hFFFF_4000);
    add_job(3, 32'h7FFF_FFFF, 32'h0000_0100);
    add_job(0, 32'h8000_0000, 32'h0001_0000);
    drain(400);
    check("rr_pulses_0", rdy_count[0], 2);
    check("rr_pulses_1", rdy_count[1], 1);
    check("rr_pulses_2", rdy_count[2], 1);
    check("rr_pulses_3", rdy_count[3], 1);

    // Backpressure: the response is held for 10 extra cycles while others wait.
    resp_ready = 1'b0;
    add_job(1, 32'h0005_0000, 32'h0003_0000);
    add_job(3, 32'hFFFF_0000, 32'hFFFF_0000);
    k = 0;
    while (!resp_valid && k < 200) begin
      tick();
      k++;
    end
    check("bp_resp_seen", resp_valid, 1'b1);
    repeat (10) tick();
    resp_ready = 1'b1;
    drain(300);

    // Random operands, edge operands, and random response backpressure.
    do_reset();
    add_job(2, 32'h8000_0000, 32'hFFFF_0000);
    add_job(1, 32'h0000_0001, 32'h7FFF_FFFF);
    for (int j = 0; j < 10; j++) begin
      logic [WIDTH-1:0] rd;
      rd = $urandom;
      if (rd == '0) rd = 32'h0000_0003;
      add_job(int'($urandom_range(0, NREQ - 1)), $urandom, rd);
    end
    k = 0;
    while (pending() != 0 && k < 2000) begin
      tick();
      resp_ready = 1'($urandom_range(0, 1));
      k++;
    end
    resp_ready = 1'b1;
    drain(200);

`ifdef DIV_ZERO_CHECK_EN
    // Division by zero bypasses the divider and saturates.
    add_job(0, 32'h0001_0000, 32'h0000_0000);
    add_job(1, 32'hFFFF_0000, 32'h0000_0000);
    add_job(2, 32'h0000_0000, 32'h0000_0000);
    drain(100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
